// File: rtl/mc_control_unit.sv
// mc_control_unit: Moore FSM sequencing fetch/decode/execute/memory/write-back for the multi-cycle CPU.
module mc_control_unit #(
   parameter int OP_W = 6
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [OP_W-1:0] opcode,
   input  logic            zero,
   output logic            PCWre,
   output logic            IRWre,
   output logic            RegWre,
   output logic            mRD,
   output logic            mWR,
   output logic            ALUSrcB,
   output logic            ExtSel,
   output logic            DBDataSrc,
   output logic            WrRegDSrc,
   output logic [1:0]      RegDst,
   output logic [1:0]      PCSrc,
   output logic [2:0]      ALUOp,
   output logic [2:0]      state
);
   typedef enum logic [2:0] {
      sIf     = 3'b000,
      sId     = 3'b001,
      sExeMem = 3'b010,
      sMem    = 3'b011,
      sWbLd   = 3'b100,
      sExeBr  = 3'b101,
      sExeAlu = 3'b110,
      sWbAlu  = 3'b111
   } state_t;

   localparam logic [OP_W-1:0] opAdd   = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] opSub   = OP_W'(6'b000001);
   localparam logic [OP_W-1:0] opAddiu = OP_W'(6'b000010);
   localparam logic [OP_W-1:0] opOri   = OP_W'(6'b010010);
   localparam logic [OP_W-1:0] opSw    = OP_W'(6'b110000);
   localparam logic [OP_W-1:0] opLw    = OP_W'(6'b110001);
   localparam logic [OP_W-1:0] opBeq   = OP_W'(6'b110100);
   localparam logic [OP_W-1:0] opJ     = OP_W'(6'b111000);
   localparam logic [OP_W-1:0] opJr    = OP_W'(6'b111001);
   localparam logic [OP_W-1:0] opJal   = OP_W'(6'b111010);
   localparam logic [OP_W-1:0] opHalt  = OP_W'(6'b111111);

   state_t curState, nextState;
   logic   halted, nextHalted;

   logic isAdd, isSub, isAddiu, isOri, isSw, isLw, isBeq, isJ, isJr, isJal, isHalt;
   logic isAlu, isMem, inId;
   logic stIf, stId, stMem, stWbLd, stExeBr, stWbAlu;

   assign isAdd   = opcode == opAdd;
   assign isSub   = opcode == opSub;
   assign isAddiu = opcode == opAddiu;
   assign isOri   = opcode == opOri;
   assign isSw    = opcode == opSw;
   assign isLw    = opcode == opLw;
   assign isBeq   = opcode == opBeq;
   assign isJ     = opcode == opJ;
   assign isJr    = opcode == opJr;
   assign isJal   = opcode == opJal;
   assign isHalt  = opcode == opHalt;
   assign isAlu   = isAdd | isSub | isAddiu | isOri;
   assign isMem   = isLw | isSw;

   assign stIf    = curState == sIf;
   assign stId    = curState == sId;
   assign stMem   = curState == sMem;
   assign stWbLd  = curState == sWbLd;
   assign stExeBr = curState == sExeBr;
   assign stWbAlu = curState == sWbAlu;

   // Decode state that actually retires jumps/NOPs; a halted or halting ID does nothing.
   assign inId = stId & ~halted & ~isHalt;

   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         curState <= sIf;
         halted   <= 1'b0;
      end else begin
         curState <= nextState;
         halted   <= nextHalted;
      end

   always_comb begin
      nextState  = sIf;
      nextHalted = halted;
      case (curState)
         sIf:     nextState = sId;
         sId:     if (halted || isHalt) begin
                     nextState  = sId;
                     nextHalted = 1'b1;
                  end else
                     nextState = isAlu ? sExeAlu : isBeq ? sExeBr : isMem ? sExeMem : sIf;
         sExeAlu: nextState = sWbAlu;
         sExeMem: nextState = sMem;
         sMem:    nextState = isLw ? sWbLd : sIf;
         default: nextState = sIf;
      endcase
   end

   // Every output is gated by RST so nothing can write while reset is held.
   always_comb begin
      PCWre     = RST & ((inId & ~isAlu & ~isBeq & ~isMem) | stExeBr | stWbAlu | (stMem & isSw) | stWbLd);
      IRWre     = RST & stIf;
      RegWre    = RST & ((inId & isJal) | stWbAlu | stWbLd);
      mRD       = RST & stMem & isLw;
      mWR       = RST & stMem & isSw;
      ALUSrcB   = RST & ~stIf & ~stId & (isAddiu | isOri | isLw | isSw);
      ExtSel    = RST & ~isOri;
      DBDataSrc = RST & stWbLd;
      WrRegDSrc = RST & (stWbAlu | stWbLd);
      RegDst    = !RST ? 2'b00 : stWbAlu ? ((isAdd | isSub) ? 2'b10 : 2'b01) : stWbLd ? 2'b01 : 2'b00;
      PCSrc     = !RST ? 2'b00 : (inId & (isJ | isJal)) ? 2'b11 : (inId & isJr) ? 2'b10 :
                  (stExeBr & zero) ? 2'b01 : 2'b00;
      ALUOp     = !RST ? 3'b000 : (isSub | isBeq) ? 3'b001 : isOri ? 3'b011 : 3'b000;
   end

   assign state = curState;
endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle control unit that sequences the CPU datapath (PC, IR, register file, ALU, data memory) through the fetch, decode, execute, memory and write-back phases.
- It is the only source of the register file's RegWre; it also drives the write-register select and write-data select.
- A Moore state machine holds the phase. Control outputs are decoded combinationally from the current state, the opcode and the ALU zero flag.

Parameters:
- OP_W, 6, opcode width

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- zero  in  1  ALU result == 0
- PCWre  out  1  PC write enable
- IRWre  out  1  instruction register write enable
- RegWre  out  1  register file write enable
- mRD  out  1  data memory read
- mWR  out  1  data memory write
- ALUSrcB  out  1  0 = rt data, 1 = extended immediate
- ExtSel  out  1  0 = zero-extend, 1 = sign-extend
- DBDataSrc  out  1  0 = ALU result, 1 = memory data
- WrRegDSrc  out  1  0 = PC+4 (jal), 1 = DB
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd
- PCSrc  out  2  00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs, 11 = jump target
- ALUOp  out  3  000 = add, 001 = sub, 011 = or
- state  out  3  current state, for debug

Behaviour:
- Opcodes:
  - add 000000, sub 000001, addiu 000010, ori 010010
  - sw 110000, lw 110001, beq 110100
  - j 111000, jr 111001, jal 111010, halt 111111
  - Any other opcode is a NOP.
- State encoding: IF 000, ID 001, EXE_MEM 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_ALU 110, WB_ALU 111. HALT is held as ID with a sticky halted flag.
- Reset (RST=0, asynchronous): state=IF, halted=0.
  - While RST=0, PCWre, IRWre, RegWre and mWR are forced to 0.
  - All other outputs are 0.
- Transitions:
  - IF→ID.
  - ID with j/jr/jal/NOP→IF.
  - ID with add/sub/addiu/ori→EXE_ALU→WB_ALU→IF.
  - ID with beq→EXE_BR→IF.
  - ID with lw/sw→EXE_MEM→MEM. From MEM, sw→IF and lw→WB_LD→IF.
  - ID with halt: set halted and remain in ID. Only reset clears halted.
- Instruction latency in cycles: j/jr/jal/NOP 2, beq 3, ALU ops 4, sw 4, lw 5.
- IRWre=1 only in IF.
- PCWre=1 only in the final state of each instruction: ID for j/jr/jal/NOP, EXE_BR, WB_ALU, MEM for sw, WB_LD. PCWre=0 for halt and when halted.
- Default PCSrc=00.
  - ID with j or jal: PCSrc=11. ID with jr: PCSrc=10.
  - EXE_BR: PCSrc=01 if zero=1, else 00.
- RegWre=1 only in:
  - ID with jal: RegDst=00, WrRegDSrc=0.
  - WB_ALU: RegDst=10 for add/sub, 01 for addiu/ori; WrRegDSrc=1, DBDataSrc=0.
  - WB_LD: RegDst=01, WrRegDSrc=1, DBDataSrc=1.
- mRD=1 in MEM for lw. mWR=1 in MEM for sw. Neither is ever asserted outside MEM.
- ALUSrcB=1 for addiu, ori, lw and sw in EXE_*/MEM/WB_* states.
- ExtSel=0 for ori, 1 otherwise.
- ALUOp:
  - sub and beq → 001.
  - ori → 011.
  - All others → 000.
- Outputs are combinational from state, opcode, zero and halted; no output is registered. They must stay stable for the whole state, given a stable opcode.
- RST asserted mid-instruction aborts it immediately. No partial write may occur after the RST fall.

Test Plan:
- Hold RST=0 for 50 ns, release; opcode=000000 → state sequence IF, ID, EXE_ALU, WB_ALU, IF. RegWre=1 with RegDst=10 only in WB_ALU. PCWre=1 only in WB_ALU.
- opcode=110001 (lw) → 5-cycle sequence ending in WB_LD: mRD=1 only in MEM; in WB_LD RegWre=1, RegDst=01, DBDataSrc=1. opcode=110000 (sw) → mWR=1 in MEM, next state IF, RegWre never asserted.
- beq with zero=1 → PCSrc=01 and PCWre=1 in EXE_BR. Repeat with zero=0 → PCSrc=00. ALUOp=001 in both cases.
- jal → 2 cycles; in ID: PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0. jr → PCSrc=10 in ID. Unknown opcode 101010 → IF, ID, IF with no RegWre or mWR.
- halt → stays in ID with PCWre=0 for 20 cycles. Pulse RST low → state=IF and IRWre=1 after release.
- Assert RST low during MEM of sw → mWR drops to 0 immediately (asynchronously) and state=IF.
